spec_accum_nch: RTL and testbench
=================================

# spec_accum_nch

Multi-channel power-spectrum accumulator for the signal-processing user logic. It sits between the power-spectrum calculator and the output formatter. It sums N_ACC pulses of spectra element-wise per lane into on-chip RAM. It then drains the accumulated frame through a valid/ready stream. Compared with the single-lane buffer it replaces, it adds parametrised lanes and width, a runtime frame length, saturating arithmetic, drain back-pressure, abort, and error/overflow flags.

## Interface
- NCH, 2: parallel lanes, each with its own RAM.
- DIN_WIDTH, 50: unsigned power-spectrum word width per lane.
- ACC_WIDTH, 64: accumulator width per lane; must be at least DIN_WIDTH.
- ADDR_WIDTH, 12: RAM depth is 2^ADDR_WIDTH words per lane.
- Ports (one clock; reset is asynchronous and active-high):
- clk_i  in  1  sole clock.
- rst_i  in  1  asynchronous active-high reset.
- start_i  in  1  arm pulse; sampled only in IDLE.
- abort_i  in  1  synchronous return to IDLE.
- frame_len_i  in  ADDR_WIDTH+1  words per pulse per lane; latched at start.
- n_acc_i  in  16  pulses to accumulate; latched at start.
- din_i  in  NCH*DIN_WIDTH  lane k occupies bits [k*DIN_WIDTH +: DIN_WIDTH].
- din_valid_i  in  1  one word per lane per valid cycle; there is no ready.
- dout_o  out  NCH*ACC_WIDTH  accumulated words, lane-packed.
- dout_valid_o  out  1  output word present.
- dout_ready_i  in  1  consumer accepts.
- busy_o  out  1  high in ACCUM or DRAIN.
- done_o  out  1  one-cycle pulse after the last drain beat.
- pulse_cnt_o  out  16  pulses completed in the current run.
- overflow_o  out  1  sticky; any lane saturated; cleared by an accepted start.
- overrun_o  out  1  sticky; din_valid_i seen in DRAIN; cleared by an accepted start.
- err_o  out  1  one-cycle pulse when a start is rejected.

## Operation
- States: IDLE, ACCUM, DRAIN.
- IDLE to ACCUM on start_i, provided frame_len_i is in 2..2^ADDR_WIDTH and n_acc_i ≠ 0.
  - Otherwise pulse err_o and stay in IDLE.
  - An accepted start latches the parameters and clears addr, pulse_cnt_o, overflow_o and overrun_o.
- ACCUM:
  - Each din_valid_i cycle issues a RAM read at addr, then increments addr.
  - When addr reaches frame_len−1, addr wraps to 0 and pulse_cnt_o increments.
  - Stage 2, one cycle later: for the first pulse, write the zero-extended din. For later pulses, write sat(mem+din).
  - No read-after-write bypass is needed because frame_len ≥ 2.
- Saturation: if the sum exceeds 2^ACC_WIDTH−1, write all-ones and set overflow_o. Lanes saturate independently.
- ACCUM to DRAIN when pulse_cnt_o reaches n_acc, after the final stage-2 write has retired.
- DRAIN:
  - Read addresses 0..frame_len−1 in order into the output register.
  - Issue a read only if the output register is empty or is being accepted in the same cycle.
  - dout_o is held stable while dout_valid_o=1 and dout_ready_i=0.
  - din_valid_i is ignored in DRAIN and sets overrun_o.
- DRAIN to IDLE when the beat at frame_len−1 is accepted. done_o pulses on the next cycle.
- abort_i, from any state: next cycle the block is in IDLE with dout_valid_o=0. No done_o is produced and the sticky flags are kept.
  - If abort_i and start_i are high together, abort wins and the start is ignored.
- Reset values: every output is 0. The state is IDLE, and all counters and flags are 0. RAM contents are don't-care, because the first pulse overwrites them.
- Reset asserted mid-run: outputs are forced to their reset values immediately. After release no partial frame is drained.

## Timing
- Accumulation write latency: a word is written 1 cycle after its din_valid_i.
- Back-to-back din_valid_i is supported at full rate, one word per lane per clock.
- DRAIN entry: one cycle after the final write.
- First dout_valid_o: 2 cycles after DRAIN entry (RAM read, then output register).
- With dout_ready_i held at 1, the drain sustains one beat per clock. The last beat is 2+frame_len−1 cycles after DRAIN entry.
- busy_o: high from the cycle after an accepted start until the cycle done_o asserts.
- pulse_cnt_o: increments on the cycle after the last word of each pulse.

## Test plan
- NCH=2, frame_len=4, n_acc=3; lane0 words [1,2,3,4] every pulse, lane1 words [10,20,30,40]:
  - drain gives lane0 [3,6,9,12] and lane1 [30,60,90,120];
  - done_o pulses once; overflow_o=0.
- Saturation, ACC_WIDTH=DIN_WIDTH=8; lane0 word 200 for 2 pulses:
  - lane0 drains 255 and overflow_o=1;
  - lane1 fed 1 drains 2.
- Back-pressure, frame_len=8, dout_ready_i toggled 1,0,0,1,…:
  - every beat is accepted exactly once, in order;
  - dout_o is stable during stalls;
  - done_o follows the 8th acceptance.
- Rejected starts:
  - frame_len=1 → err_o pulse and busy_o stays 0;
  - n_acc=0 → err_o pulse and busy_o stays 0;
  - frame_len=2^ADDR_WIDTH → accepted.
- Abort and start high together mid-ACCUM (pulse 2 of 4):
  - IDLE next cycle, no drain, dout_valid_o=0;
  - a new run with n_acc=1 drains the raw input only, with no stale sums.
- rst_i asserted for 3 cycles mid-DRAIN:
  - all outputs 0 immediately;
  - after release, din_valid_i input produces no output until a start;
  - din_valid_i during DRAIN sets overrun_o.

Source files
------------

// File: rtl/spec_accum_nch.sv
// Multi-lane power-spectrum accumulator: sums n_acc pulses element-wise per lane
// into on-chip RAM with saturation, then drains the frame over a valid/ready stream.
module spec_accum_nch #(
  parameter int NCH        = 2,
  parameter int DIN_WIDTH  = 50,
  parameter int ACC_WIDTH  = 64,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic [ADDR_WIDTH:0]      frame_len_i,
  input  logic [15:0]              n_acc_i,
  input  logic [NCH*DIN_WIDTH-1:0] din_i,
  input  logic                     din_valid_i,
  output logic [NCH*ACC_WIDTH-1:0] dout_o,
  output logic                     dout_valid_o,
  input  logic                     dout_ready_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [15:0]              pulse_cnt_o,
  output logic                     overflow_o,
  output logic                     overrun_o,
  output logic                     err_o
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN} state_t;

  localparam logic [ADDR_WIDTH:0] LEN_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] LEN_MIN = {{(ADDR_WIDTH-1){1'b0}}, 2'b10};
  localparam logic [ADDR_WIDTH:0] LEN_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  // Top bit of the result flags saturation; lower bits are the clamped sum.
  function automatic logic [ACC_WIDTH:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                 input logic [DIN_WIDTH-1:0] b);
    logic [ACC_WIDTH:0] s;
    s = {1'b0, a} + (ACC_WIDTH+1)'(b);
    if (s[ACC_WIDTH]) s = {1'b1, {ACC_WIDTH{1'b1}}};
    return s;
  endfunction

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH:0]     frame_len_q;
  logic [15:0]             n_acc_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [15:0]             pulse_cnt_q;
  logic                    overflow_q, overrun_q, err_q, done_q;
  logic                    vld_p1;
  logic [ADDR_WIDTH-1:0]   addr_p1;
  logic                    first_p1;
  logic [ADDR_WIDTH:0]     drain_addr_q;
  logic                    rd_vld_q, rd_last_q, out_vld_q, out_last_q;
  logic [NCH-1:0]          lane_sat;

  logic start_ok, accept_start, reject_start, acc_en, addr_last, accum_done;
  logic out_free, rd_move, drain_issue, beat_last_acc, rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;

  assign start_ok      = (frame_len_i >= LEN_MIN) && (frame_len_i <= LEN_MAX) && (n_acc_i != 16'd0);
  assign accept_start  = (state_q == S_IDLE) && start_i && !abort_i && start_ok;
  assign reject_start  = (state_q == S_IDLE) && start_i && !abort_i && !start_ok;
  assign acc_en        = (state_q == S_ACCUM) && din_valid_i && (pulse_cnt_q != n_acc_q);
  assign addr_last     = ({1'b0, addr_q} == (frame_len_q - LEN_ONE));
  // The last stage-2 write retires on the same edge that moves us to DRAIN.
  assign accum_done    = (state_q == S_ACCUM) && (pulse_cnt_q == n_acc_q);

  assign out_free      = !out_vld_q || dout_ready_i;
  assign rd_move       = rd_vld_q && out_free;
  assign drain_issue   = (state_q == S_DRAIN) && (drain_addr_q < frame_len_q) && (!rd_vld_q || out_free);
  assign beat_last_acc = (state_q == S_DRAIN) && out_vld_q && dout_ready_i && out_last_q;
  assign rd_en         = acc_en || drain_issue;
  assign rd_addr       = (state_q == S_DRAIN) ? drain_addr_q[ADDR_WIDTH-1:0] : addr_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept_start)  state_d = S_ACCUM;
      S_ACCUM: if (accum_done)    state_d = S_DRAIN;
      S_DRAIN: if (beat_last_acc) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      frame_len_q  <= '0;
      n_acc_q      <= '0;
      addr_q       <= '0;
      pulse_cnt_q  <= '0;
      overflow_q   <= 1'b0;
      overrun_q    <= 1'b0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      vld_p1       <= 1'b0;
      drain_addr_q <= '0;
      rd_vld_q     <= 1'b0;
      out_vld_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= reject_start;
      done_q  <= beat_last_acc && !abort_i;
      vld_p1  <= acc_en && !abort_i;
      if (accept_start) begin
        frame_len_q <= frame_len_i;
        n_acc_q     <= n_acc_i;
        addr_q      <= '0;
        pulse_cnt_q <= '0;
        overflow_q  <= 1'b0;
        overrun_q   <= 1'b0;
      end else begin
        if (acc_en) begin
          if (addr_last) begin
            addr_q      <= '0;
            pulse_cnt_q <= pulse_cnt_q + 16'd1;
          end else begin
            addr_q <= addr_q + ADDR_WIDTH'(1);
          end
        end
        if (|lane_sat) overflow_q <= 1'b1;
        if ((state_q == S_DRAIN) && din_valid_i) overrun_q <= 1'b1;
      end
      if (state_q != S_DRAIN)  drain_addr_q <= '0;
      else if (drain_issue)    drain_addr_q <= drain_addr_q + LEN_ONE;
      // Two-slot drain pipe: RAM read register feeding the output register.
      if (abort_i || state_q != S_DRAIN) rd_vld_q <= 1'b0;
      else if (drain_issue)              rd_vld_q <= 1'b1;
      else if (rd_move)                  rd_vld_q <= 1'b0;
      if (abort_i || state_q != S_DRAIN) out_vld_q <= 1'b0;
      else if (rd_move)                  out_vld_q <= 1'b1;
      else if (dout_ready_i)             out_vld_q <= 1'b0;
    end
  end

  // Stage 1 -> stage 2 bookkeeping, qualified by vld_p1 / rd_vld_q / out_vld_q
  always_ff @(posedge clk_i) begin
    if (acc_en) begin
      addr_p1  <= addr_q;
      first_p1 <= (pulse_cnt_q == 16'd0);
    end
    if (drain_issue) rd_last_q  <= (drain_addr_q == (frame_len_q - LEN_ONE));
    if (rd_move)     out_last_q <= rd_last_q;
  end

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    logic [ACC_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [ACC_WIDTH-1:0] rd_p1;
    logic [DIN_WIDTH-1:0] din_p1;
    logic [ACC_WIDTH-1:0] out_p2;
    logic [ACC_WIDTH:0]   sum_p1;

    assign sum_p1 = sat_add(rd_p1, din_p1);

    // Stage 1: RAM read; stage 2: write-back; drain: output register
    always_ff @(posedge clk_i) begin
      if (rd_en)  rd_p1  <= mem[rd_addr];
      if (acc_en) din_p1 <= din_i[k*DIN_WIDTH +: DIN_WIDTH];
      if (vld_p1) mem[addr_p1] <= first_p1 ? ACC_WIDTH'(din_p1) : sum_p1[ACC_WIDTH-1:0];
      if (rd_move) out_p2 <= rd_p1;
    end

    assign lane_sat[k] = vld_p1 && !first_p1 && sum_p1[ACC_WIDTH];
    assign dout_o[k*ACC_WIDTH +: ACC_WIDTH] = out_vld_q ? out_p2 : '0;
  end

  assign dout_valid_o = out_vld_q;
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = done_q;
  assign pulse_cnt_o  = pulse_cnt_q;
  assign overflow_o   = overflow_q;
  assign overrun_o    = overrun_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_spec_accum_nch.sv
// Scoreboard bench for spec_accum_nch: a 50/64-bit instance for the main flows and
// an 8/8-bit instance for saturation.
module tb_spec_accum_nch;
  typedef logic [127:0] beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic         start, abort, din_valid, dout_ready, dout_valid, busy, done;
  logic         overflow, overrun, err;
  logic [12:0]  frame_len;
  logic [15:0]  n_acc, pulse_cnt;
  logic [99:0]  din;
  logic [127:0] dout;

  logic         s_start, s_abort, s_din_valid, s_dout_ready, s_dout_valid, s_busy, s_done;
  logic         s_overflow, s_overrun, s_err;
  logic [3:0]   s_frame_len;
  logic [15:0]  s_n_acc, s_pulse_cnt, s_din, s_dout;

  spec_accum_nch #(.NCH(2), .DIN_WIDTH(50), .ACC_WIDTH(64), .ADDR_WIDTH(12)) u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .frame_len_i(frame_len),
    .n_acc_i(n_acc), .din_i(din), .din_valid_i(din_valid), .dout_o(dout),
    .dout_valid_o(dout_valid), .dout_ready_i(dout_ready), .busy_o(busy), .done_o(done),
    .pulse_cnt_o(pulse_cnt), .overflow_o(overflow), .overrun_o(overrun), .err_o(err));

  spec_accum_nch #(.NCH(2), .DIN_WIDTH(8), .ACC_WIDTH(8), .ADDR_WIDTH(3)) u_sat (
    .clk_i(clk), .rst_i(rst), .start_i(s_start), .abort_i(s_abort), .frame_len_i(s_frame_len),
    .n_acc_i(s_n_acc), .din_i(s_din), .din_valid_i(s_din_valid), .dout_o(s_dout),
    .dout_valid_o(s_dout_valid), .dout_ready_i(s_dout_ready), .busy_o(s_busy), .done_o(s_done),
    .pulse_cnt_o(s_pulse_cnt), .overflow_o(s_overflow), .overrun_o(s_overrun), .err_o(s_err));

  int checks = 0;
  int failures = 0;
  beat_t exp_q[$];
  logic [15:0] sexp_q[$];
  logic [63:0] acc0[16];
  logic [63:0] acc1[16];

  function automatic logic [63:0] msat(input logic [63:0] a, input logic [49:0] b);
    logic [64:0] s;
    s = {1'b0, a} + {15'b0, b};
    return s[64] ? 64'hFFFF_FFFF_FFFF_FFFF : s[63:0];
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_start(input int fl, input int na);
    frame_len = 13'(fl);
    n_acc     = 16'(na);
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  // Drives one word per lane and updates the reference accumulators.
  task automatic feed_word(input longint a, input longint b, input int idx,
                           input bit first, input bit last_pulse);
    acc0[idx] = first ? 64'(50'(a)) : msat(acc0[idx], 50'(a));
    acc1[idx] = first ? 64'(50'(b)) : msat(acc1[idx], 50'(b));
    din       = {50'(b), 50'(a)};
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    if (last_pulse) exp_q.push_back({acc1[idx], acc0[idx]});
  endtask

  task automatic get_beat(output beat_t d, output bit ok);
    ok = 1'b0;
    d  = '0;
    for (int i = 0; i < 100; i++) begin
      if (dout_valid && dout_ready) begin
        d  = dout;
        ok = 1'b1;
        step();
        return;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (dout !== 128'd0) begin failures++; $display("FAIL reset_dout got=%0h want=0", dout); end
    checks++;
    if ({dout_valid, busy, done, overflow, overrun, err} !== 6'd0) begin
      failures++; $display("FAIL reset_flags got=%b want=000000", {dout_valid, busy, done, overflow, overrun, err});
    end
    checks++;
    if (pulse_cnt !== 16'd0) begin failures++; $display("FAIL reset_pulse_cnt got=%0d want=0", pulse_cnt); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    beat_t d, e;
    bit ok;
    do_start(4, 3);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b want=1", busy); end
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 4; i++) feed_word(i + 1, (i + 1) * 10, i, p == 0, p == 2);
      checks++;
      if (pulse_cnt !== 16'(p + 1)) begin failures++; $display("FAIL basic_pulse_cnt got=%0d want=%0d", pulse_cnt, p + 1); end
      step();
    end
    dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      get_beat(d, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL basic_beat%0d timeout got=none want=beat", i); end
      else begin
        e = exp_q.pop_front();
        if (d !== e) begin failures++; $display("FAIL basic_beat%0d got=%0h want=%0h", i, d, e); end
      end
    end
    checks++;
    if ({done, busy} !== 2'b10) begin failures++; $display("FAIL basic_done got=%b want=10", {done, busy}); end
    step();
    checks++;
    if ({done, overflow, dout_valid} !== 3'b000) begin
      failures++; $display("FAIL basic_after got=%b want=000", {done, overflow, dout_valid});
    end
  endtask

  task automatic test_backpressure();
    beat_t e, prev;
    int acc, early;
    bit stalled;
    acc = 0; early = 0; stalled = 1'b0; prev = '0;
    do_start(8, 1);
    for (int i = 0; i < 8; i++) feed_word(3 * i + 1, 5 * i + 100, i, 1'b1, 1'b1);
    for (int k = 0; k < 200 && acc < 8; k++) begin
      dout_ready = (k % 3 == 0);
      if (done) early++;
      if (stalled) begin
        checks++;
        if (!dout_valid || dout !== prev) begin failures++; $display("FAIL bp_stall_stable got=%0h want=%0h", dout, prev); end
      end
      if (dout_valid && dout_ready) begin
        e = exp_q.pop_front();
        checks++;
        if (dout !== e) begin failures++; $display("FAIL bp_beat%0d got=%0h want=%0h", acc, dout, e); end
        acc++;
      end
      stalled = dout_valid && !dout_ready;
      prev    = dout;
      step();
    end
    checks++;
    if (acc != 8) begin failures++; $display("FAIL bp_count got=%0d want=8", acc); end
    checks++;
    if ({done, early[0]} !== 2'b10 || early != 0) begin
      failures++; $display("FAIL bp_done got=%b early=%0d want=1 early=0", done, early);
    end
    dout_ready = 1'b1;
    step();
  endtask

  task automatic test_reject();
    do_start(1, 3);
    checks++;
    if ({err, busy} !== 2'b10) begin failures++; $display("FAIL rej_len1 got=%b want=10", {err, busy}); end
    step();
    checks++;
    if ({err, busy} !== 2'b00) begin failures++; $display("FAIL rej_len1_after got=%b want=00", {err, busy}); end
    do_start(4, 0);
    checks++;
    if ({err, busy} !== 2'b10) begin failures++; $display("FAIL rej_nacc0 got=%b want=10", {err, busy}); end
    step();
    do_start(4096, 1);
    checks++;
    if ({err, busy} !== 2'b01) begin failures++; $display("FAIL acc_len_max got=%b want=01", {err, busy}); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if ({busy, dout_valid} !== 2'b00) begin failures++; $display("FAIL rej_abort got=%b want=00", {busy, dout_valid}); end
  endtask

  task automatic test_abort();
    beat_t d, e;
    bit ok;
    int seen;
    do_start(4, 4);
    for (int i = 0; i < 4; i++) feed_word(100 + i, 200 + i, i, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) feed_word(100 + i, 200 + i, i, 1'b0, 1'b0);
    abort = 1'b1; start = 1'b1; frame_len = 13'd4; n_acc = 16'd1;
    step();
    abort = 1'b0; start = 1'b0;
    checks++;
    if ({busy, dout_valid, err} !== 3'b000) begin failures++; $display("FAIL abort_idle got=%b want=000", {busy, dout_valid, err}); end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (dout_valid || done || busy) seen++;
      step();
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL abort_no_drain got=%0d want=0", seen); end
    do_start(4, 1);
    for (int i = 0; i < 4; i++) feed_word(7 + i, 70 + i, i, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      get_beat(d, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL abort_rerun%0d timeout got=none want=beat", i); end
      else begin
        e = exp_q.pop_front();
        if (d !== e) begin failures++; $display("FAIL abort_rerun%0d got=%0h want=%0h", i, d, e); end
      end
    end
    step();
  endtask

  task automatic test_saturation();
    logic [7:0] m0[2];
    logic [7:0] m1[2];
    logic [7:0] w0[2];
    logic [8:0] s;
    logic [15:0] e;
    int got;
    w0[0] = 8'd200; w0[1] = 8'd50;
    s_frame_len = 4'd2; s_n_acc = 16'd2; s_start = 1'b1;
    step();
    s_start = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 2; i++) begin
        if (p == 0) begin m0[i] = w0[i]; m1[i] = 8'd1; end
        else begin
          s = {1'b0, m0[i]} + {1'b0, w0[i]};
          m0[i] = s[8] ? 8'hFF : s[7:0];
          m1[i] = m1[i] + 8'd1;
          sexp_q.push_back({m1[i], m0[i]});
        end
        s_din = {8'd1, w0[i]};
        s_din_valid = 1'b1;
        step();
        s_din_valid = 1'b0;
      end
    end
    s_dout_ready = 1'b1;
    got = 0;
    for (int k = 0; k < 60 && got < 2; k++) begin
      if (s_dout_valid && s_dout_ready) begin
        e = sexp_q.pop_front();
        checks++;
        if (s_dout !== e) begin failures++; $display("FAIL sat_beat%0d got=%0h want=%0h", got, s_dout, e); end
        got++;
      end
      step();
    end
    checks++;
    if (got != 2) begin failures++; $display("FAIL sat_count got=%0d want=2", got); end
    checks++;
    if (s_overflow !== 1'b1) begin failures++; $display("FAIL sat_overflow got=%b want=1", s_overflow); end
  endtask

  task automatic test_reset_mid_drain();
    beat_t d, e;
    bit ok;
    int seen;
    do_start(4, 1);
    for (int i = 0; i < 4; i++) feed_word(40 + i, 60 + i, i, 1'b1, 1'b1);
    dout_ready = 1'b0;
    for (int i = 0; i < 20 && !dout_valid; i++) step();
    checks++;
    if (dout_valid !== 1'b1) begin failures++; $display("FAIL rst_reach_drain got=%b want=1", dout_valid); end
    rst = 1'b1;
    #1;
    checks++;
    if ({dout_valid, busy, done, overflow, overrun, err} !== 6'd0 || dout !== 128'd0 || pulse_cnt !== 16'd0) begin
      failures++; $display("FAIL rst_immediate got=%b/%0h/%0d want=0/0/0",
                           {dout_valid, busy, done, overflow, overrun, err}, dout, pulse_cnt);
    end
    step(); step(); step();
    rst = 1'b0;
    exp_q.delete();
    dout_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 14; i++) begin
      din_valid = (i < 4);
      if (dout_valid || busy) seen++;
      step();
    end
    din_valid = 1'b0;
    checks++;
    if (seen != 0) begin failures++; $display("FAIL rst_no_output got=%0d want=0", seen); end
    do_start(4, 1);
    for (int i = 0; i < 4; i++) feed_word(90 + i, 30 + i, i, 1'b1, 1'b1);
    dout_ready = 1'b0;
    for (int i = 0; i < 20 && !dout_valid; i++) step();
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_set got=%b want=1", overrun); end
    dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      get_beat(d, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL overrun_beat%0d timeout got=none want=beat", i); end
      else begin
        e = exp_q.pop_front();
        if (d !== e) begin failures++; $display("FAIL overrun_beat%0d got=%0h want=%0h", i, d, e); end
      end
    end
    checks++;
    if ({done, overrun} !== 2'b11) begin failures++; $display("FAIL overrun_sticky got=%b want=11", {done, overrun}); end
    do_start(4, 1);
    checks++;
    if ({overrun, busy} !== 2'b01) begin failures++; $display("FAIL overrun_clear got=%b want=01", {overrun, busy}); end
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  initial begin
    start = 0; abort = 0; din_valid = 0; dout_ready = 0; frame_len = '0; n_acc = '0; din = '0;
    s_start = 0; s_abort = 0; s_din_valid = 0; s_dout_ready = 0; s_frame_len = '0; s_n_acc = '0; s_din = '0;
    rst = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_reject();
    test_abort();
    test_saturation();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1);
  end

endmodule
